// File: rtl/adc_axis_framer.sv
// adc_axis_framer: cuts the continuous ADC sample stream into frames of a
// runtime-programmable length and marks the last word of each frame with
// TLAST. A two-entry output buffer keeps every output registered and sustains
// one word per cycle. Frame count and a sticky stall flag go to the status word.
//
// Optional feature: define ADC_FRAMER_HEADER_EN to prefix every frame with a
// header word {HEADER_TAG, frameCount}. Without it, frames are data words only.
module adc_axis_framer #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter logic [15:0] HEADER_TAG         = 16'hA5A5
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  // sample stream from the ADC
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tlast,
  // framed stream towards the DMA/FIFO
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                            m00_axis_tlast,
  // PS control / status
  input  logic [3:0]                      control,
  input  logic [15:0]                     frameLength,
  output logic [31:0]                     status
);

  localparam int unsigned DW = C_AXIS_TDATA_WIDTH;
  localparam int unsigned SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned LW = 16;
  localparam int unsigned CW = 2;

`ifdef ADC_FRAMER_HEADER_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_DATA   = 2'd2,
    S_DONE   = 2'd3
  } state_t;
  localparam state_t S_FRAME_START = S_HEADER;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd2,
    S_DONE   = 2'd3
  } state_t;
  localparam state_t S_FRAME_START = S_DATA;
`endif

  logic clk;
  logic rst_n;
  assign clk   = s00_axis_aclk;
  assign rst_n = s00_axis_aresetn;

  logic enable;
  logic clear;
  logic single_shot;
  assign enable      = control[0];
  assign clear       = control[1];
  assign single_shot = control[2];

  state_t state_q, state_nxt;

  logic [LW-1:0] len_q, len_nxt;
  logic [LW-1:0] beat_q, beat_nxt;
  logic [LW-1:0] len_in;
  logic [15:0]   frame_count_q, frame_count_nxt;
  logic          stall_q, stall_nxt;
  logic          busy_q;
  logic          s_tready_q, s_tready_nxt;
  logic          frame_done;

  // output buffer: head entry drives the master port, slot holds the overflow
  logic [CW-1:0] count_q, count_nxt;
  logic [DW-1:0] head_data_q, head_data_nxt;
  logic          head_last_q, head_last_nxt;
  logic [DW-1:0] slot_data_q, slot_data_nxt;
  logic          slot_last_q, slot_last_nxt;
  logic          m_tvalid_q;
  logic [SW-1:0] m_tstrb_q;

  logic          push;
  logic [DW-1:0] push_data;
  logic          push_last;
  logic          pop;
  logic          accept;
  logic          buf_full;

  // zero length is treated as a one-word frame
  assign len_in   = (frameLength == '0) ? LW'(1) : frameLength;
  assign buf_full = (count_q == CW'(2));
  assign accept   = s00_axis_tvalid & s_tready_q;
  assign pop      = m_tvalid_q & m00_axis_tready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // next-state, frame bookkeeping and buffer push request
  always_comb begin
    state_nxt  = state_q;
    len_nxt    = len_q;
    beat_nxt   = beat_q;
    push       = 1'b0;
    push_data  = s00_axis_tdata;
    push_last  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) begin
          len_nxt   = len_in;
          beat_nxt  = '0;
          state_nxt = S_FRAME_START;
        end
      end
`ifdef ADC_FRAMER_HEADER_EN
      S_HEADER: begin
        if (!buf_full) begin
          push      = 1'b1;
          push_data = DW'({HEADER_TAG, frame_count_q});
          state_nxt = S_DATA;
        end
      end
`endif
      S_DATA: begin
        if (accept) begin
          push      = 1'b1;
          push_last = (beat_q == len_q - LW'(1));
          beat_nxt  = beat_q + LW'(1);
          if (push_last) begin
            frame_done = 1'b1;
            if (single_shot) begin
              state_nxt = S_DONE;
            end else if (enable) begin
              len_nxt   = len_in;
              beat_nxt  = '0;
              state_nxt = S_FRAME_START;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // counters and sticky flag; clear has priority over increment/set
  always_comb begin
    frame_count_nxt = frame_count_q;
    stall_nxt       = stall_q;
    if (frame_done) begin
      frame_count_nxt = frame_count_q + 16'd1;
    end
    if ((state_q == S_DATA) && s00_axis_tvalid && !s_tready_q) begin
      stall_nxt = 1'b1;
    end
    if (clear) begin
      frame_count_nxt = '0;
      stall_nxt       = 1'b0;
    end
  end

  // two-entry output buffer, order preserving
  always_comb begin
    count_nxt     = count_q;
    head_data_nxt = head_data_q;
    head_last_nxt = head_last_q;
    slot_data_nxt = slot_data_q;
    slot_last_nxt = slot_last_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == CW'(0)) begin
          head_data_nxt = push_data;
          head_last_nxt = push_last;
          count_nxt     = CW'(1);
        end else begin
          slot_data_nxt = push_data;
          slot_last_nxt = push_last;
          count_nxt     = CW'(2);
        end
      end
      2'b01: begin
        if (count_q == CW'(2)) begin
          head_data_nxt = slot_data_q;
          head_last_nxt = slot_last_q;
        end
        count_nxt = count_q - CW'(1);
      end
      2'b11: begin
        if (count_q == CW'(2)) begin
          head_data_nxt = slot_data_q;
          head_last_nxt = slot_last_q;
          slot_data_nxt = push_data;
          slot_last_nxt = push_last;
        end else begin
          head_data_nxt = push_data;
          head_last_nxt = push_last;
        end
      end
      default: begin
        count_nxt = count_q;
      end
    endcase
  end

  // input ready for the coming cycle, derived from next state and occupancy
  always_comb begin
    s_tready_nxt = 1'b1;
    case (state_nxt)
      S_DATA:  s_tready_nxt = (count_nxt != CW'(2));
`ifdef ADC_FRAMER_HEADER_EN
      S_HEADER: s_tready_nxt = 1'b0;
`endif
      default: s_tready_nxt = 1'b1;
    endcase
  end

  // datapath, counter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q         <= LW'(1);
      beat_q        <= '0;
      frame_count_q <= '0;
      stall_q       <= 1'b0;
      busy_q        <= 1'b0;
      s_tready_q    <= 1'b0;
      count_q       <= '0;
      head_data_q   <= '0;
      head_last_q   <= 1'b0;
      slot_data_q   <= '0;
      slot_last_q   <= 1'b0;
      m_tvalid_q    <= 1'b0;
      m_tstrb_q     <= '0;
    end else begin
      len_q         <= len_nxt;
      beat_q        <= beat_nxt;
      frame_count_q <= frame_count_nxt;
      stall_q       <= stall_nxt;
      busy_q        <= (state_nxt != S_IDLE);
      s_tready_q    <= s_tready_nxt;
      count_q       <= count_nxt;
      head_data_q   <= head_data_nxt;
      head_last_q   <= head_last_nxt;
      slot_data_q   <= slot_data_nxt;
      slot_last_q   <= slot_last_nxt;
      m_tvalid_q    <= (count_nxt != CW'(0));
      m_tstrb_q     <= (count_nxt != CW'(0)) ? {SW{1'b1}} : '0;
    end
  end

  assign s00_axis_tready = s_tready_q;
  assign m00_axis_tvalid = m_tvalid_q;
  assign m00_axis_tdata  = head_data_q;
  assign m00_axis_tlast  = head_last_q & m_tvalid_q;
  assign m00_axis_tstrb  = m_tstrb_q;
  assign status          = {frame_count_q, 14'd0, stall_q, busy_q};

  // inputs that the framer accepts but deliberately ignores
  logic unused_inputs;
  assign unused_inputs = ^{s00_axis_tstrb, s00_axis_tlast, control[3], HEADER_TAG};

endmodule

// File: tb/tb_adc_axis_framer.sv
// Directed self-checking bench for adc_axis_framer.
module tb_adc_axis_framer;

`ifdef ADC_FRAMER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;
  logic [3:0]  control;
  logic [15:0] frame_length;
  logic [31:0] status;

  int tests;
  int errors;

  logic [32:0] got[$];
  logic [32:0] exp[$];

  adc_axis_framer dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tready  (s_tready),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (4'hF),
    .s00_axis_tlast   (1'b0),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tready  (m_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .m00_axis_tlast   (m_tlast),
    .control          (control),
    .frameLength      (frame_length),
    .status           (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every completed output handshake
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    control  = '0;
    frame_length = 16'd4;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    got.delete();
    exp.delete();
  endtask

  task automatic exp_header(input logic [15:0] fc);
    if (HDR_EN) exp.push_back({1'b0, 16'hA5A5, fc});
  endtask

  // offer one word and wait (bounded) until it is accepted
  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    forever begin
      @(negedge clk);
      if (s_tready) break;
      n++;
      if (n > 200) begin
        tests++; errors++;
        $display("FAIL send_word timeout data=%h", d);
        break;
      end
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1;
    control = '0; frame_length = 16'd4;
    #3;
    tests++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset.m_tvalid got %b exp 0", m_tvalid); end
    tests++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset.m_tdata got %h exp 0", m_tdata); end
    tests++; if (m_tstrb !== 4'h0) begin errors++; $display("FAIL reset.m_tstrb got %h exp 0", m_tstrb); end
    tests++; if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset.m_tlast got %b exp 0", m_tlast); end
    tests++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset.s_tready got %b exp 0", s_tready); end
    tests++; if (status !== 32'h0) begin errors++; $display("FAIL reset.status got %h exp 0", status); end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    tests++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset.idle_ready got %b exp 1", s_tready); end
    tests++; if (status !== 32'h0) begin errors++; $display("FAIL reset.idle_status got %h exp 0", status); end
  endtask

  task automatic test_frames();
    apply_reset();
    frame_length = 16'd4;
    control = 4'b0001;
    repeat (2) @(posedge clk); #1;
    for (int f = 0; f < 3; f++) begin
      exp_header(16'(f));
      for (int b = 0; b < 4; b++) exp.push_back({(b == 3), 32'(f * 4 + b)});
    end
    for (int i = 0; i < 12; i++) begin
      if (i == 11) control = 4'b0000;
      send_word(32'(i));
      if (i == 0) begin
        tests++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h0 || m_tlast !== 1'b0 || m_tstrb !== 4'hF) begin
          errors++; $display("FAIL frames.latency got v=%b d=%h l=%b s=%h exp v=1 d=0 l=0 s=f", m_tvalid, m_tdata, m_tlast, m_tstrb);
        end
      end
    end
    drain();
    tests++; if (got.size() != exp.size()) begin errors++; $display("FAIL frames.count got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin errors++; $display("FAIL frames.word[%0d] got %h exp %h", i, got[i], exp[i]); end
    end
    tests++; if (status[31:16] !== 16'd3) begin errors++; $display("FAIL frames.frame_count got %0d exp 3", status[31:16]); end
    tests++; if (status[1:0] !== 2'b00) begin errors++; $display("FAIL frames.stall_busy got %b exp 00", status[1:0]); end
    tests++; if (m_tvalid !== 1'b0 || m_tstrb !== 4'h0) begin errors++; $display("FAIL frames.empty got v=%b s=%h exp v=0 s=0", m_tvalid, m_tstrb); end
  endtask

  task automatic test_len_zero();
    apply_reset();
    frame_length = 16'd0;
    control = 4'b0001;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      exp_header(16'(i));
      exp.push_back({1'b1, 32'hA0 + 32'(i)});
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) control = 4'b0000;
      send_word(32'hA0 + 32'(i));
    end
    drain();
    tests++; if (got.size() != exp.size()) begin errors++; $display("FAIL len0.count got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin errors++; $display("FAIL len0.word[%0d] got %h exp %h", i, got[i], exp[i]); end
    end
    tests++; if (status[31:16] !== 16'd3) begin errors++; $display("FAIL len0.frame_count got %0d exp 3", status[31:16]); end
  endtask

  task automatic test_backpressure();
    logic held_ok;
    apply_reset();
    frame_length = 16'd8;
    control = 4'b0001;
    repeat (2) @(posedge clk); #1;
    exp_header(16'd0);
    for (int b = 0; b < 8; b++) exp.push_back({(b == 7), 32'h80 + 32'(b)});
    for (int i = 0; i < 3; i++) send_word(32'h80 + 32'(i));
    m_tready = 1'b0;
    send_word(32'h83);
    s_tvalid = 1'b1;
    s_tdata  = 32'h84;
    held_ok  = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (s_tready !== 1'b0 || m_tvalid !== 1'b1 || m_tdata !== 32'h82 || m_tlast !== 1'b0 || m_tstrb !== 4'hF)
        held_ok = 1'b0;
    end
    tests++; if (held_ok !== 1'b1) begin errors++; $display("FAIL bp.hold got tready=%b v=%b d=%h exp tready=0 v=1 d=82", s_tready, m_tvalid, m_tdata); end
    @(posedge clk); #1;
    m_tready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      if (i == 7) control = 4'b0000;
      send_word(32'h80 + 32'(i));
    end
    drain();
    tests++; if (got.size() != exp.size()) begin errors++; $display("FAIL bp.count got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin errors++; $display("FAIL bp.word[%0d] got %h exp %h", i, got[i], exp[i]); end
    end
    tests++; if (status[1] !== 1'b1) begin errors++; $display("FAIL bp.stall got %b exp 1", status[1]); end
    tests++; if (status[31:16] !== 16'd1) begin errors++; $display("FAIL bp.frame_count got %0d exp 1", status[31:16]); end
    control = 4'b0010;
    @(posedge clk); #1;
    control = 4'b0000;
    tests++; if (status !== 32'h0) begin errors++; $display("FAIL bp.clear got %h exp 0", status); end
  endtask

  task automatic test_single_shot();
    apply_reset();
    frame_length = 16'd4;
    control = 4'b0101;
    repeat (2) @(posedge clk); #1;
    exp_header(16'd0);
    for (int b = 0; b < 4; b++) exp.push_back({(b == 3), 32'h100 + 32'(b)});
    for (int i = 0; i < 10; i++) send_word(32'h100 + 32'(i));
    drain();
    tests++; if (s_tready !== 1'b1) begin errors++; $display("FAIL single.done_ready got %b exp 1", s_tready); end
    tests++; if (status[0] !== 1'b1) begin errors++; $display("FAIL single.done_busy got %b exp 1", status[0]); end
    control = 4'b0000;
    repeat (2) @(posedge clk); #1;
    tests++; if (status[0] !== 1'b0) begin errors++; $display("FAIL single.idle_busy got %b exp 0", status[0]); end
    tests++; if (got.size() != exp.size()) begin errors++; $display("FAIL single.count got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin errors++; $display("FAIL single.word[%0d] got %h exp %h", i, got[i], exp[i]); end
    end
    tests++; if (status[31:16] !== 16'd1) begin errors++; $display("FAIL single.frame_count got %0d exp 1", status[31:16]); end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    frame_length = 16'd6;
    control = 4'b0001;
    repeat (2) @(posedge clk); #1;
    exp_header(16'd0);
    for (int b = 0; b < 6; b++) exp.push_back({(b == 5), 32'h50 + 32'(b)});
    for (int i = 0; i < 3; i++) send_word(32'h50 + 32'(i));
    control = 4'b0000;
    frame_length = 16'd2;
    for (int i = 3; i < 7; i++) send_word(32'h50 + 32'(i));
    drain();
    tests++; if (got.size() != exp.size()) begin errors++; $display("FAIL endrop.count got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin errors++; $display("FAIL endrop.word[%0d] got %h exp %h", i, got[i], exp[i]); end
    end
    tests++; if (status !== 32'h0001_0000) begin errors++; $display("FAIL endrop.status got %h exp 00010000", status); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    frame_length = 16'd8;
    control = 4'b0001;
    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send_word(32'h60 + 32'(i));
    tests++; if (m_tvalid !== 1'b1 || m_tdata !== 32'h62) begin errors++; $display("FAIL rstmid.pre got v=%b d=%h exp v=1 d=62", m_tvalid, m_tdata); end
    rst_n = 1'b0;
    control = 4'b0000;
    #1;
    tests++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL rstmid.flush got v=%b l=%b exp v=0 l=0", m_tvalid, m_tlast); end
    tests++; if (status !== 32'h0) begin errors++; $display("FAIL rstmid.status got %h exp 0", status); end
    @(posedge clk); #1 rst_n = 1'b1;
    drain();
    exp_header(16'd0);
    exp.push_back({1'b0, 32'h60});
    exp.push_back({1'b0, 32'h61});
    tests++; if (got.size() != exp.size()) begin errors++; $display("FAIL rstmid.count got %0d exp %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      tests++; if (got[i] !== exp[i]) begin errors++; $display("FAIL rstmid.word[%0d] got %h exp %h", i, got[i], exp[i]); end
    end
    tests++; if (status[31:16] !== 16'd0) begin errors++; $display("FAIL rstmid.frame_count got %0d exp 0", status[31:16]); end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    test_reset();
    test_frames();
    test_len_zero();
    test_backpressure();
    test_single_shot();
    test_enable_drop();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/adc_axis_framer.md
# adc_axis_framer

Framing stage placed directly downstream of the AD9244 ADC AXI-Stream master, ahead of the DMA/FIFO. Consumes the continuous 32-bit sample stream, cuts it into frames of a runtime-programmable length, and asserts TLAST on the last word of each frame. A two-entry output skid buffer provides registered outputs and full throughput. Frame count and a sticky backpressure flag are reported to the PS over a status word.

## Interface
- C_AXIS_TDATA_WIDTH, 32, data width of both stream sides
- HEADER_TAG, 16'hA5A5, upper half of the optional header word
- s00_axis_aclk  in  1  single clock for both stream sides
- s00_axis_aresetn  in  1  asynchronous, active-low reset
- s00_axis_tvalid / s00_axis_tready  in / out  1  input handshake
- s00_axis_tdata  in  32  ADC sample word; s00_axis_tstrb (4) and s00_axis_tlast (1) accepted and ignored
- m00_axis_tvalid / m00_axis_tready  out / in  1  output handshake
- m00_axis_tdata  out  32  framed word
- m00_axis_tstrb  out  4  4'hF while tvalid, else 0
- m00_axis_tlast  out  1  high on last word of frame
- control  in  4  [0] enable, [1] clear counters, [2] single-shot, [3] reserved
- frameLength  in  16  words per frame, latched at frame start; 0 treated as 1
- status  out  32  [0] busy (not IDLE), [1] stall sticky, [15:2] zero, [31:16] frameCount

## Operation
- States: IDLE, HEADER (only with macro), DATA, DONE.
- IDLE: s_tready=1, incoming words consumed and discarded. On enable=1: latch frameLength (0→1), clear beat counter, go to HEADER, or to DATA without macro.
- HEADER: when buffer has space, push {HEADER_TAG, frameCount[15:0]}, tlast=0; s_tready=0 in this state; → DATA.
- DATA: s_tready = !bufFull. Each accepted word pushed with tlast = (beat == len-1); beat increments. On the last accept: frameCount++ (16-bit wrap); then single-shot → DONE; else enable=1 → relatch length, HEADER/DATA; else → IDLE.
- enable dropped mid-frame: frame completes to its latched length, then IDLE. Length changes mid-frame ignored.
- DONE: s_tready=1, words discarded; enable=0 → IDLE.
- Stall flag: set on any cycle in DATA with s_tvalid=1 and s_tready=0; clears only on control[1] or reset.
- control[1] (level): clears frameCount and stall flag; wins over a simultaneous increment/set.
- Output buffer: 2-entry skid, entries carry {tdata, tlast}; order preserved; no word dropped or duplicated once accepted.

## Timing
- Reset (async assert, sync release): state IDLE, buffer empty, frameCount 0, stall 0, m00_axis_tvalid/tdata/tstrb/tlast 0, s00_axis_tready 0 while reset is low.
- Latency: word accepted at edge N appears on m00_axis_tdata after edge N (visible in cycle N+1).
- Throughput: 1 word/cycle sustained in DATA with m_tready=1; HEADER costs one input bubble per frame.
- m_tvalid never drops without handshake; tdata/tlast stable while tvalid=1 and tready=0.
- bufFull registered; s_tready deasserts the cycle after the second entry fills; simultaneous push and pop at occupancy 2 is not permitted (tready already low), at 1 keeps occupancy 1.
- Length 1: every data word carries tlast.
- Reset mid-frame: buffer flushed, partial frame lost, no tlast emitted.

## Configuration
- ADC_FRAMER_HEADER_EN defined: HEADER state present; each frame is 1 header word + frameLength data words, tlast on the final data word.
- Undefined: HEADER state removed; frames are exactly frameLength data words; HEADER_TAG unused.

## Test plan
- Reset, enable=1, frameLength=4, m_tready=1, ramp 0..11 → three frames, tlast on 3,7,11, status[31:16]=3, stall=0 (header build: header words tagged A5A50000, A5A50001, A5A50002 before each frame).
- frameLength=0, 3 words → every word has tlast, frameCount=3.
- frameLength=8, m_tready low 5 cycles mid-frame → s_tready drops after 2 buffered, stall=1, output order intact; control[1] pulse → stall=0, frameCount=0.
- Single-shot, frameLength=4, 10 words → one frame of 4, status[0]=0 after DONE exit, remaining words discarded, s_tready=1.
- enable cleared after beat 2 of frameLength=6 → beats 3–5 still framed with tlast on 5, then IDLE.
- Reset asserted at beat 3 → m_tvalid=0 immediately, frameCount unchanged-by-frame (0), no tlast.
